// File: rtl/fib_sequencer.sv
// rtl/fib_sequencer.sv - timed Fibonacci operation sequencer for a register file and ALU
//
// Steps a register file and ALU through operations 0..NUM_REGS. Each operation
// is one ISSUE cycle followed by STEP_CYCLES-1 WAIT cycles.
//   Op 0        clears the register file.
//   Ops 1, 2    seed R0 and R1 with 1.
//   Ops 3..N    write R[k-1] = R[k-3] + R[k-2].
//
// Ports:
//   Clk, RESET_N                 rising-edge clock, asynchronous active-low reset
//   Start, Mode                  launch from IDLE/HALT; Mode 0 loops, 1 single pass
//   Pause, Step                  freeze dwell timer; force next op while paused
//   Alu_Carry                    ALU carry-out of the current operation
//   Reg_Read_A/B, Reg_Write      register-file addresses (held for the whole op)
//   Write_Enable, Reg_Reset      register-file strobes (ISSUE cycle only)
//   OpCode                       ALU instruction
//   Op_Index                     current operation number 0..NUM_REGS
//   Busy, Done, Overflow         status flags

`ifndef ADDI
`define ADDI 4'h1
`endif
`ifndef RTYPE
`define RTYPE 4'h2
`endif
`ifndef EXT_ADD
`define EXT_ADD 4'h3
`endif

module fib_sequencer #(
  parameter int  DATA_W      = 16,
  parameter int  NUM_REGS    = 16,
  parameter int  STEP_CYCLES = 150000000,
  localparam int REG_AW      = $clog2(NUM_REGS),
  localparam int IDX_W       = $clog2(NUM_REGS + 1)
) (
  input  logic              Clk,
  input  logic              RESET_N,
  input  logic              Start,
  input  logic              Mode,
  input  logic              Pause,
  input  logic              Step,
  input  logic              Alu_Carry,
  output logic [REG_AW-1:0] Reg_Read_A,
  output logic [REG_AW-1:0] Reg_Read_B,
  output logic [REG_AW-1:0] Reg_Write,
  output logic              Write_Enable,
  output logic              Reg_Reset,
  output logic [15:0]       OpCode,
  output logic [IDX_W-1:0]  Op_Index,
  output logic              Busy,
  output logic              Done,
  output logic              Overflow
);

  localparam int TMR_W = $clog2(STEP_CYCLES);
  localparam logic [IDX_W-1:0] LAST_OP  = IDX_W'(NUM_REGS);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(STEP_CYCLES - 2);

  if (DATA_W < 1 || NUM_REGS < 4 || (NUM_REGS & (NUM_REGS - 1)) != 0 || STEP_CYCLES < 2)
  begin : g_param_check
    $error("fib_sequencer: illegal parameter set");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HALT} state_t;

  state_t            r_state;
  logic [TMR_W-1:0]  r_timer;
  logic [IDX_W-1:0]  r_op_idx;
  logic              r_mode;
  logic [REG_AW-1:0] r_rd_a;
  logic [REG_AW-1:0] r_rd_b;
  logic [REG_AW-1:0] r_wr;
  logic              r_we;
  logic              r_rr;
  logic [15:0]       r_opcode;
  logic              r_busy;
  logic              r_done;
  logic              r_ovf;

  logic              w_start;
  logic              w_advance;
  logic              w_last;
  logic              w_halt;
  logic              w_load;
  logic [IDX_W-1:0]  w_nxt_idx;
  logic [REG_AW-1:0] w_nxt_lo;
  logic [REG_AW-1:0] w_nxt_a;
  logic [REG_AW-1:0] w_nxt_b;
  logic [REG_AW-1:0] w_nxt_w;
  logic              w_nxt_we;
  logic              w_nxt_rr;
  logic [15:0]       w_nxt_opc;

  assign w_start   = (r_state == S_IDLE || r_state == S_HALT) && Start;
  // Pause gates expiry, so a pause on the expiry cycle holds the op.
  assign w_advance = (r_state == S_WAIT) && (Pause ? Step : (r_timer == '0));
  assign w_last    = (r_op_idx == LAST_OP);
  assign w_halt    = w_advance && w_last && r_mode;
  assign w_load    = w_start || (w_advance && !w_halt);
  assign w_nxt_idx = (w_start || w_last) ? '0 : r_op_idx + 1'b1;
  assign w_nxt_lo  = w_nxt_idx[REG_AW-1:0];

  // Address/opcode decode of the operation about to be issued.
  always_comb begin
    w_nxt_a   = '0;
    w_nxt_b   = '0;
    w_nxt_w   = '0;
    w_nxt_we  = 1'b0;
    w_nxt_rr  = 1'b0;
    w_nxt_opc = {`ADDI, 4'b0, 8'd0};
    if (w_nxt_idx == '0) begin
      w_nxt_rr = 1'b1;
    end else if (w_nxt_idx <= IDX_W'(2)) begin
      // Top register is still zero after the clear, so +1 seeds R0 and R1.
      w_nxt_a   = REG_AW'(NUM_REGS - 1);
      w_nxt_b   = REG_AW'(NUM_REGS - 1);
      w_nxt_w   = (w_nxt_idx == IDX_W'(2)) ? REG_AW'(1) : '0;
      w_nxt_we  = 1'b1;
      w_nxt_opc = {`ADDI, 4'b0, 8'd1};
    end else begin
      // Modulo-NUM_REGS subtraction also yields the right addresses for op NUM_REGS.
      w_nxt_a   = w_nxt_lo - REG_AW'(3);
      w_nxt_b   = w_nxt_lo - REG_AW'(2);
      w_nxt_w   = w_nxt_lo - REG_AW'(1);
      w_nxt_we  = 1'b1;
      w_nxt_opc = {`RTYPE, 4'b0, `EXT_ADD, 4'b0};
    end
  end

  always_ff @(posedge Clk or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state  <= S_IDLE;
      r_timer  <= '0;
      r_op_idx <= '0;
      r_mode   <= 1'b0;
      r_rd_a   <= '0;
      r_rd_b   <= '0;
      r_wr     <= '0;
      r_we     <= 1'b0;
      r_rr     <= 1'b0;
      r_opcode <= 16'h0000;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_we <= 1'b0;
      r_rr <= 1'b0;
      if (w_start) begin
        r_mode <= Mode;
        r_busy <= 1'b1;
        r_done <= 1'b0;
        r_ovf  <= 1'b0;
      end
      if (w_load) begin
        r_state  <= S_ISSUE;
        r_op_idx <= w_nxt_idx;
        r_rd_a   <= w_nxt_a;
        r_rd_b   <= w_nxt_b;
        r_wr     <= w_nxt_w;
        r_we     <= w_nxt_we;
        r_rr     <= w_nxt_rr;
        r_opcode <= w_nxt_opc;
      end else if (w_halt) begin
        r_state <= S_HALT;
        r_busy  <= 1'b0;
        r_done  <= 1'b1;
      end else if (r_state == S_ISSUE) begin
        r_state <= S_WAIT;
        r_timer <= TMR_LOAD;
        if (r_op_idx >= IDX_W'(3) && Alu_Carry) begin
          r_ovf <= 1'b1;
        end
      end else if (r_state == S_WAIT && !Pause) begin
        r_timer <= r_timer - 1'b1;
      end
    end
  end

  assign Reg_Read_A   = r_rd_a;
  assign Reg_Read_B   = r_rd_b;
  assign Reg_Write    = r_wr;
  assign Write_Enable = r_we;
  assign Reg_Reset    = r_rr;
  assign OpCode       = r_opcode;
  assign Op_Index     = r_op_idx;
  assign Busy         = r_busy;
  assign Done         = r_done;
  assign Overflow     = r_ovf;

endmodule

// File: doc/fib_sequencer.md
FIB_SEQUENCER -- requirements
Module: fib_sequencer

Interface
REQ-001 Parameter DATA_W, default 16: ALU/register data width.
REQ-002 Parameter NUM_REGS, default 16: register-file depth; power of two, at least 4; REG_AW = $clog2(NUM_REGS).
REQ-003 Parameter STEP_CYCLES, default 150000000: clocks per operation; at least 2.
REQ-004 Port Clk  in  1: the single clock, rising edge.
REQ-005 Port RESET_N  in  1: asynchronous, active-low reset.
REQ-006 Port Start  in  1: launch a sequence from IDLE or HALT.
REQ-007 Port Mode  in  1: 0 = loop forever, 1 = single pass then halt; sampled on accepted Start.
REQ-008 Port Pause  in  1: freeze dwell timer while high.
REQ-009 Port Step  in  1: when paused, advance to next operation.
REQ-010 Port Alu_Carry  in  1: ALU carry-out flag for the current operation.
REQ-011 Port Reg_Read_A, Reg_Read_B, Reg_Write  out  REG_AW each: register-file addresses.
REQ-012 Port Write_Enable  out  1: register-file write strobe.
REQ-013 Port Reg_Reset  out  1: register-file clear strobe.
REQ-014 Port OpCode  out  16: ALU instruction, built from `ADDI / `RTYPE / `EXT_ADD in parameters.vh.
REQ-015 Port Op_Index  out  $clog2(NUM_REGS+1): current operation number.
REQ-016 Port Busy, Done, Overflow  out  1 each: status flags.

Function
REQ-017 States are IDLE, ISSUE, WAIT and HALT; one operation equals one ISSUE cycle plus STEP_CYCLES-1 WAIT cycles.
REQ-018 Operation k ranges from 0 to NUM_REGS; addresses and OpCode are registered and held constant from ISSUE through the end of WAIT.
REQ-019 Op 0: Reg_Reset=1 for the ISSUE cycle only, Write_Enable=0, OpCode={`ADDI,4'b0,8'd0}.
REQ-020 Op 1: Read_A=Read_B=NUM_REGS-1, Write=0, OpCode={`ADDI,4'b0,8'd1}.
REQ-021 Op 2: Read_A=Read_B=NUM_REGS-1, Write=1, OpCode={`ADDI,4'b0,8'd1}.
REQ-022 Op k in 3..NUM_REGS: Read_A=k-3, Read_B=k-2, Write=k-1, OpCode={`RTYPE,4'b0,`EXT_ADD,4'b0}.
REQ-023 Write_Enable=1 only during the ISSUE cycle of ops 1..NUM_REGS, and is 0 in every other cycle.
REQ-024 IDLE/HALT with Start=1 goes to ISSUE op 0 on the next cycle, sets Busy=1, and clears Done and Overflow; Start is ignored while Busy=1.
REQ-025 WAIT with Pause=0 decrements the timer; at expiry it issues op k+1.
REQ-026 After the op NUM_REGS WAIT expires: Mode=0 issues op 0; Mode=1 enters HALT with Done=1 and Busy=0.
REQ-027 Pause=1 holds the timer and all outputs; no ISSUE occurs.
REQ-028 Pause=1 with Step=1 forces ISSUE of the next operation on the following cycle, regardless of the timer.
REQ-029 Step is ignored when Pause=0 and in IDLE/HALT.
REQ-030 Pause=1 on the same cycle as timer expiry: the pause wins and no ISSUE occurs.
REQ-031 Alu_Carry is sampled in the ISSUE cycle of ops 3..NUM_REGS; if it is 1, Overflow=1 from the next cycle, sticky until Start or reset.
REQ-032 Overflow does not stop the sequence.
REQ-033 Op_Index wraps from NUM_REGS to 0 in Mode 0, and is held at NUM_REGS in HALT.

Reset
REQ-034 RESET_N=0 immediately forces state IDLE, timer 0 and Op_Index 0.
REQ-035 Under reset, all address outputs, Write_Enable, Reg_Reset, Busy, Done and Overflow are 0, and OpCode is 16'h0000.
REQ-036 Reset asserted mid-operation, including mid-ISSUE, aborts with no further strobes.
REQ-037 After RESET_N deasserts, the block waits in IDLE for Start; reset alone never causes an ISSUE.

Verification (STEP_CYCLES=4, behavioural regfile+ALU model attached)
REQ-038 DATA_W=16, NUM_REGS=16, Mode=1, Start pulse -> 17 ISSUEs exactly 4 cycles apart; then HALT, Done=1, R15=987, R2=2, Overflow=0.
REQ-039 DATA_W=8, NUM_REGS=16, Mode=1 -> first carry on op 14 (R13=377 mod 256 = 121); Overflow=1 from the next cycle and the pass still completes.
REQ-040 Mode=0 -> after op 16 WAIT, op 0 ISSUE with Reg_Reset=1 and Op_Index=0; Done stays 0.
REQ-041 Pause=1 during op 5 WAIT for 20 cycles -> no ISSUE; Step pulse -> op 6 ISSUE on the next cycle; Pause released -> 4-cycle cadence resumes.
REQ-042 RESET_N low during op 7 ISSUE -> Write_Enable=0 immediately and IDLE; Start afterwards -> op 0 first.
REQ-043 Start held high while Busy -> no restart; Op_Index advances normally.
